// File: rtl/bram_pattern_writer.sv
// Fills a BRAM region through port B with a seeded pattern, then optionally
// reads it back and counts mismatches against the same pattern.
module bram_pattern_writer #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 32,
  parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_4000_0000,
  parameter int          DEPTH      = 16,
  parameter int          RD_LAT     = 1
) (
  input  logic                    clk40,
  input  logic                    rst40,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [DATA_WIDTH-1:0]   seed,
  input  logic                    verify_en,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             err_cnt,
  output logic [ADDR_WIDTH-1:0]   first_err_addr,
  output logic [ADDR_WIDTH-1:0]   addrb,
  output logic [DATA_WIDTH-1:0]   dinb,
  input  logic [DATA_WIDTH-1:0]   doutb,
  output logic                    clkb,
  output logic                    enb,
  output logic                    rstb,
  output logic [DATA_WIDTH/8-1:0] web
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_VERIFY, S_DRAIN, S_DONE} state_t;

  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [IDX_W-1:0] i);
    logic [63:0] a;
    a = BASE_ADDR + 64'(i) * 64'(NB);
    return ADDR_WIDTH'(a);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [1:0] m,
                                                    input logic [DATA_WIDTH-1:0] s,
                                                    input logic [IDX_W-1:0] i);
    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] p;
    sum = s + DATA_WIDTH'(i);
    case (m)
      2'd0:    p = sum;
      2'd1:    p = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << (32'(i) % DATA_WIDTH);
      2'd2:    p = s;
      default: p = ~sum;
    endcase
    return p;
  endfunction

  state_t                 state, state_n;
  logic [IDX_W-1:0]       idx, idx_n;
  logic [1:0]             drain_cnt, drain_n;
  logic [1:0]             mode_q;
  logic [DATA_WIDTH-1:0]  seed_q;
  logic                   verify_q;
  logic                   enb_n;
  logic [NB-1:0]          web_n;
  logic [ADDR_WIDTH-1:0]  addrb_n;
  logic [DATA_WIDTH-1:0]  dinb_n;
  logic                   accept;
  logic [RD_LAT-1:0]      pv;
  logic [IDX_W-1:0]       pidx [RD_LAT];
  logic [IDX_W-1:0]       cmp_idx;
  logic                   mismatch;

  assign accept   = start && (state == S_IDLE || state == S_DONE);
  assign busy     = state inside {S_WRITE, S_VERIFY, S_DRAIN};
  assign done     = (state == S_DONE);
  assign clkb     = clk40;
  assign rstb     = 1'b0;
  assign cmp_idx  = pidx[RD_LAT-1];
  assign mismatch = pv[RD_LAT-1] && (doutb != pattern(mode_q, seed_q, cmp_idx));

  // Next values of the registered BRAM port are computed here so the port
  // lines up with the state it belongs to.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // skipped an assignment would infer a latch.
    state_n = state;
    idx_n   = idx;
    drain_n = drain_cnt;
    enb_n   = 1'b0;
    web_n   = '0;
    addrb_n = addrb;
    dinb_n  = dinb;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_n = S_WRITE;
          idx_n   = '0;
          enb_n   = 1'b1;
          web_n   = '1;
          addrb_n = word_addr('0);
          dinb_n  = pattern(mode, seed, '0);
        end
      end
      S_WRITE: begin
        if (idx == LAST_IDX) begin
          if (verify_q) begin
            state_n = S_VERIFY;
            idx_n   = '0;
            enb_n   = 1'b1;
            addrb_n = word_addr('0);
          end else begin
            state_n = S_DONE;
          end
        end else begin
          idx_n   = idx + 1'b1;
          enb_n   = 1'b1;
          web_n   = '1;
          addrb_n = word_addr(idx_n);
          dinb_n  = pattern(mode_q, seed_q, idx_n);
        end
      end
      S_VERIFY: begin
        if (idx == LAST_IDX) begin
          state_n = S_DRAIN;
          drain_n = '0;
        end else begin
          idx_n   = idx + 1'b1;
          enb_n   = 1'b1;
          addrb_n = word_addr(idx_n);
        end
      end
      S_DRAIN: begin
        if (drain_cnt == 2'(RD_LAT - 1)) state_n = S_DONE;
        else                              drain_n = drain_cnt + 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk40) begin
    if (rst40) begin
      state          <= S_IDLE;
      idx            <= '0;
      drain_cnt      <= '0;
      mode_q         <= '0;
      seed_q         <= '0;
      verify_q       <= 1'b0;
      enb            <= 1'b0;
      web            <= '0;
      addrb          <= '0;
      dinb           <= '0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      pv             <= '0;
      for (int i = 0; i < RD_LAT; i++) pidx[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples the
      // pre-edge values, independent of statement order.
      state     <= state_n;
      idx       <= idx_n;
      drain_cnt <= drain_n;
      enb       <= enb_n;
      web       <= web_n;
      addrb     <= addrb_n;
      dinb      <= dinb_n;
      // Read pipeline carries the word index alongside the BRAM latency.
      pv[0]   <= (state == S_VERIFY);
      pidx[0] <= idx;
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i]   <= pv[i-1];
        pidx[i] <= pidx[i-1];
      end
      if (accept) begin
        mode_q         <= mode;
        seed_q         <= seed;
        verify_q       <= verify_en;
        err_cnt        <= '0;
        first_err_addr <= '0;
      end else if (mismatch) begin
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        if (err_cnt == 16'd0)    first_err_addr <= word_addr(cmp_idx);
      end
    end
  end

endmodule

// File: tb/tb_bram_pattern_writer.sv
// Bench for bram_pattern_writer: default-size instance with a 1-cycle BRAM
// model, plus a DEPTH=1 / RD_LAT=3 instance with a 3-cycle BRAM model.
module tb_bram_pattern_writer;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h4000_0000;

  logic        clk40 = 1'b0;
  always #5 clk40 = ~clk40;

  logic        rst40, start, verify_en;
  logic [1:0]  mode;
  logic [31:0] seed;
  logic        busy, done, clkb, enb, rstb;
  logic [15:0] err_cnt;
  logic [31:0] first_err_addr, addrb, dinb, doutb;
  logic [3:0]  web;

  logic        s_start, s_verify, s_busy, s_done, s_clkb, s_enb, s_rstb;
  logic [1:0]  s_mode;
  logic [31:0] s_seed, s_first, s_addrb, s_dinb, s_doutb;
  logic [15:0] s_err;
  logic [3:0]  s_web;

  bram_pattern_writer dut (
    .clk40(clk40), .rst40(rst40), .start(start), .mode(mode), .seed(seed),
    .verify_en(verify_en), .busy(busy), .done(done), .err_cnt(err_cnt),
    .first_err_addr(first_err_addr), .addrb(addrb), .dinb(dinb), .doutb(doutb),
    .clkb(clkb), .enb(enb), .rstb(rstb), .web(web)
  );

  bram_pattern_writer #(.DEPTH(1), .RD_LAT(3)) dut_small (
    .clk40(clk40), .rst40(rst40), .start(s_start), .mode(s_mode), .seed(s_seed),
    .verify_en(s_verify), .busy(s_busy), .done(s_done), .err_cnt(s_err),
    .first_err_addr(s_first), .addrb(s_addrb), .dinb(s_dinb), .doutb(s_doutb),
    .clkb(s_clkb), .enb(s_enb), .rstb(s_rstb), .web(s_web)
  );

  // BRAM models; a corrupted word reads back with bit 0 flipped.
  logic [31:0] mem [DEPTH];
  bit          corrupt [DEPTH];
  function automatic int widx(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return int'(o[5:2]);
  endfunction
  always @(posedge clk40) begin
    if (enb && web == 4'hF) mem[widx(addrb)] <= dinb;
    if (enb && web == 4'h0) doutb <= mem[widx(addrb)] ^ (corrupt[widx(addrb)] ? 32'h1 : 32'h0);
  end

  logic [31:0] s_mem, s_r1, s_r2, s_r3;
  bit          s_corrupt;
  always @(posedge clk40) begin
    if (s_enb && s_web == 4'hF) s_mem <= s_dinb;
    if (s_enb && s_web == 4'h0) s_r1 <= s_mem ^ {31'b0, s_corrupt};
    s_r2 <= s_r1;
    s_r3 <= s_r2;
  end
  assign s_doutb = s_r3;

  // Access monitor for the main instance, sampled mid-cycle.
  int          cyc = 0;
  int          web_bad = 0;
  logic [31:0] wr_addr[$], wr_data[$], rd_addr[$];
  int          wr_cyc[$], rd_cyc[$];
  always @(negedge clk40) begin
    cyc = cyc + 1;
    if (enb) begin
      if (web == 4'hF) begin
        wr_addr.push_back(addrb); wr_data.push_back(dinb); wr_cyc.push_back(cyc);
      end else if (web == 4'h0) begin
        rd_addr.push_back(addrb); rd_cyc.push_back(cyc);
      end else begin
        web_bad = web_bad + 1;
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_pat(input int m, input logic [31:0] s, input int i);
    logic [31:0] p;
    case (m)
      0: p = s + 32'(i);
      1: begin
        p = 32'd1;
        for (int k = 0; k < i % 32; k++) p = p * 2;
      end
      2: p = s;
      default: p = ~(s + 32'(i));
    endcase
    return p;
  endfunction

  task automatic start_pass(input int m, input logic [31:0] s, input bit v);
    wr_addr.delete(); wr_data.delete(); rd_addr.delete(); wr_cyc.delete(); rd_cyc.delete();
    @(negedge clk40);
    start = 1'b1; mode = 2'(m); seed = s; verify_en = v;
    @(negedge clk40);
    start = 1'b0;
    check("first_wr_enb", enb, 1);
    check("first_wr_web", web, 4'hF);
    check("first_wr_addr", addrb, BASE);
    check("first_wr_data", dinb, ref_pat(m, s, 0));
    check("start_busy", busy, 1);
    check("start_done_clr", done, 0);
    check("start_err_clr", err_cnt, 0);
    check("start_first_clr", first_err_addr, 0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk40);
      n++;
    end
    check("done_reached", done, 1);
    check("done_not_busy", busy, 0);
    check("done_enb_low", enb, 0);
  endtask

  task automatic check_pass(input int m, input logic [31:0] s, input bit v,
                            input int exp_err, input logic [31:0] exp_first);
    check("wr_count", wr_addr.size(), DEPTH);
    for (int i = 0; i < wr_addr.size(); i++) begin
      check($sformatf("wr_addr[%0d]", i), wr_addr[i], BASE + 32'(4 * i));
      check($sformatf("wr_data[%0d]", i), wr_data[i], ref_pat(m, s, i));
    end
    if (wr_cyc.size() == DEPTH) check("wr_back_to_back", wr_cyc[DEPTH-1] - wr_cyc[0], DEPTH - 1);
    check("rd_count", rd_addr.size(), v ? DEPTH : 0);
    for (int i = 0; i < rd_addr.size(); i++)
      check($sformatf("rd_addr[%0d]", i), rd_addr[i], BASE + 32'(4 * i));
    if (v && rd_cyc.size() == DEPTH) check("rd_back_to_back", rd_cyc[DEPTH-1] - rd_cyc[0], DEPTH - 1);
    check("err_cnt", err_cnt, exp_err);
    check("first_err_addr", first_err_addr, exp_first);
  endtask

  typedef struct {
    int          mode;
    logic [31:0] seed;
    bit          ver;
    int          bad_word;
    int          exp_err;
    logic [31:0] exp_first;
  } vec_t;

  typedef struct {
    bit enb;
    bit wr;
    bit busy;
    bit done;
  } step_t;

  task automatic run_small(input bit c, input int exp_err, input logic [31:0] exp_first);
    step_t steps [6];
    steps[0] = '{1, 1, 1, 0};
    steps[1] = '{1, 0, 1, 0};
    steps[2] = '{0, 0, 1, 0};
    steps[3] = '{0, 0, 1, 0};
    steps[4] = '{0, 0, 1, 0};
    steps[5] = '{0, 0, 0, 1};
    s_corrupt = c;
    @(negedge clk40);
    s_start = 1'b1; s_mode = 2'd0; s_seed = 32'h77; s_verify = 1'b1;
    @(negedge clk40);
    s_start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("s_enb[%0d]", k), s_enb, steps[k].enb);
      check($sformatf("s_web[%0d]", k), s_web, steps[k].wr ? 4'hF : 4'h0);
      check($sformatf("s_busy[%0d]", k), s_busy, steps[k].busy);
      check($sformatf("s_done[%0d]", k), s_done, steps[k].done);
      if (k < 5) @(negedge clk40);
    end
    check("s_addrb", s_addrb, BASE);
    check("s_dinb", s_dinb, 32'h77);
    check("s_err_cnt", s_err, exp_err);
    check("s_first_err", s_first, exp_first);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [6];
    int          n, rm, exp_err;
    logic [31:0] rs, exp_first;
    bit          rv;

    vecs[0] = '{0, 32'h0,         0, -1, 0, 32'h0};
    vecs[1] = '{1, 32'h0,         1, -1, 0, 32'h0};
    vecs[2] = '{1, 32'h0,         1,  5, 1, 32'h4000_0014};
    vecs[3] = '{3, 32'h1234,      1,  0, 1, 32'h4000_0000};
    vecs[4] = '{0, 32'hFFFF_FFF8, 1, 15, 1, 32'h4000_003C};
    vecs[5] = '{2, 32'hDEAD_BEEF, 0,  4, 0, 32'h0};

    rst40 = 1'b1; start = 1'b0; mode = 2'd0; seed = '0; verify_en = 1'b0;
    s_start = 1'b0; s_mode = 2'd0; s_seed = '0; s_verify = 1'b0; s_corrupt = 1'b0;
    for (int i = 0; i < DEPTH; i++) corrupt[i] = 1'b0;
    repeat (3) @(negedge clk40);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_enb", enb, 0);
    check("rst_web", web, 0);
    check("rst_addrb", addrb, 0);
    check("rst_dinb", dinb, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_first_err", first_err_addr, 0);
    check("rstb_low", rstb, 0);
    check("clkb_follows", clkb, clk40);
    rst40 = 1'b0;

    foreach (vecs[v]) begin
      for (int i = 0; i < DEPTH; i++) corrupt[i] = (i == vecs[v].bad_word);
      start_pass(vecs[v].mode, vecs[v].seed, vecs[v].ver);
      wait_done();
      check_pass(vecs[v].mode, vecs[v].seed, vecs[v].ver, vecs[v].exp_err, vecs[v].exp_first);
    end

    // Reset during the write of word 7, with a coincident start.
    for (int i = 0; i < DEPTH; i++) corrupt[i] = 1'b0;
    start_pass(0, 32'h100, 0);
    n = 0;
    while (!(enb && addrb == BASE + 32'd28) && n < 20) begin
      @(negedge clk40);
      n++;
    end
    check("reached_word7", addrb, BASE + 32'd28);
    rst40 = 1'b1; start = 1'b1; mode = 2'd2;
    @(negedge clk40);
    rst40 = 1'b0; start = 1'b0;
    check("abort_enb", enb, 0);
    check("abort_web", web, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_addrb", addrb, 0);
    repeat (20) @(negedge clk40);
    check("abort_wr_count", wr_addr.size(), 8);
    if (wr_data.size() == 8) check("abort_last_data", wr_data[7], 32'h107);
    check("abort_stays_idle", busy, 0);

    // start held while busy is ignored; start in DONE restarts at once.
    corrupt[3] = 1'b1;
    start_pass(0, 32'h10, 1);
    repeat (3) @(negedge clk40);
    start = 1'b1; mode = 2'd2; seed = 32'hA5A5_A5A5; verify_en = 1'b0;
    repeat (5) @(negedge clk40);
    start = 1'b0;
    check("busy_during_ignored_start", busy, 1);
    wait_done();
    check_pass(0, 32'h10, 1, 1, BASE + 32'd12);
    start_pass(2, 32'hA5A5_A5A5, 0);
    wait_done();
    check_pass(2, 32'hA5A5_A5A5, 0, 0, 32'h0);

    // Random passes against the reference model.
    for (int r = 0; r < 8; r++) begin
      rm = int'($urandom_range(0, 3));
      rs = $urandom;
      rv = 1'($urandom_range(0, 1));
      exp_err = 0;
      exp_first = 32'h0;
      for (int i = 0; i < DEPTH; i++) begin
        corrupt[i] = ($urandom_range(0, 3) == 0);
        if (rv && corrupt[i]) begin
          if (exp_err == 0) exp_first = BASE + 32'(4 * i);
          exp_err++;
        end
      end
      start_pass(rm, rs, rv);
      wait_done();
      check_pass(rm, rs, rv, exp_err, exp_first);
    end

    check("web_all_or_none", web_bad, 0);

    run_small(1'b0, 0, 32'h0);
    run_small(1'b1, 1, BASE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bram_pattern_writer.md
BRAM_PATTERN_WRITER -- requirements
Module: bram_pattern_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: BRAM port-B data width; multiple of 8, 8..64.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: width of addrb (byte address).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h40000000: byte address of word 0.
REQ-004 SHALL have parameter DEPTH, default 16: words per pass, 1..65536.
REQ-005 SHALL have parameter RD_LAT, default 1: cycles from read address to valid doutb, 1..3.
REQ-006 clk40  input  1  sole clock; all logic on rising edge.
REQ-007 rst40  input  1  synchronous, active-high reset.
REQ-008 start  input  1  single-cycle request to begin a pass.
REQ-009 mode  input  2  pattern select, sampled on accepted start.
REQ-010 seed  input  DATA_WIDTH  pattern seed, sampled on accepted start.
REQ-011 verify_en  input  1  read-back-and-compare enable, sampled on accepted start.
REQ-012 busy  output  1  high in WRITE, VERIFY and DRAIN.
REQ-013 done  output  1  high in DONE; stays high until next accepted start or reset.
REQ-014 err_cnt  output  16  mismatch count of last verify pass.
REQ-015 first_err_addr  output  ADDR_WIDTH  byte address of first mismatch; 0 if none.
REQ-016 addrb  output  ADDR_WIDTH  BRAM port-B byte address, registered.
REQ-017 dinb  output  DATA_WIDTH  BRAM write data, registered.
REQ-018 doutb  input  DATA_WIDTH  BRAM read data.
REQ-019 clkb  output  1  equals clk40.
REQ-020 enb  output  1  BRAM enable, registered.
REQ-021 rstb  output  1  tied 0.
REQ-022 web  output  DATA_WIDTH/8  byte write enables, registered; all ones or all zeros.

Function
REQ-023 States SHALL be IDLE, WRITE, VERIFY, DRAIN, DONE.
REQ-024 start SHALL be accepted only in IDLE or DONE; ignored while busy.
REQ-025 On accepted start SHALL latch mode/seed/verify_en, clear idx, err_cnt, first_err_addr and done, enter WRITE next cycle.
REQ-026 Word idx (0..DEPTH-1) address SHALL be BASE_ADDR + idx*(DATA_WIDTH/8), truncated to ADDR_WIDTH.
REQ-027 Pattern P(idx), truncated to DATA_WIDTH: mode 0 seed+idx; mode 1 1 rotated left by (idx mod DATA_WIDTH); mode 2 seed; mode 3 ~(seed+idx).
REQ-028 WRITE: each cycle enb=1, web all ones, addrb/dinb for idx; exactly DEPTH consecutive write cycles, idx 0 first.
REQ-029 After write of idx DEPTH-1: VERIFY if verify_en latched, else DONE.
REQ-030 VERIFY: enb=1, web=0, addrb for idx 0..DEPTH-1 over DEPTH consecutive cycles; then DRAIN for RD_LAT cycles with enb=0.
REQ-031 doutb sampled RD_LAT cycles after each read address SHALL be compared with P(idx); pipeline carries idx.
REQ-032 Each mismatch SHALL increment err_cnt, saturating at 16'hFFFF; first mismatch SHALL load first_err_addr.
REQ-033 DRAIN SHALL go to DONE after last compare; err_cnt final when done rises.
REQ-034 In IDLE and DONE, enb=0 and web=0; addrb and dinb hold last values.
REQ-035 DEPTH=1 SHALL give one write cycle and, with verify, one read cycle.
REQ-036 start in DONE SHALL begin a new pass with no idle cycle.

Reset
REQ-037 rst40 high SHALL, next edge, force IDLE, busy=0, done=0, enb=0, web=0, addrb=0, dinb=0, err_cnt=0, first_err_addr=0, pipeline cleared.
REQ-038 Reset mid-WRITE/VERIFY SHALL abort with no further BRAM access; start coincident with rst40 ignored.

Verification
REQ-039 Defaults, mode 0, seed 0, verify_en 0, start -> 16 writes addrb 0x40000000..0x4000003C step 4, dinb 0..15, then done=1, busy=0.
REQ-040 mode 1, verify_en 1, BRAM model RD_LAT=1 -> dinb 1,2,4,..,0x8000; 16 reads; err_cnt=0; first_err_addr=0.
REQ-041 As REQ-040, model corrupts word 5 -> err_cnt=1, first_err_addr=0x40000014.
REQ-042 rst40 pulsed during write of idx 7 -> next cycle enb=0, web=0, busy=0, done=0; no further writes.
REQ-043 start held during busy, then in DONE with mode 2 seed 0xA5A5A5A5 -> busy-time start ignored; new pass writes constant 0xA5A5A5A5 and begins the cycle after acceptance.
REQ-044 DEPTH=1, RD_LAT=3, verify_en 1 -> one write, one read, 3 DRAIN cycles, then done.
